// File: rtl/as2650_io_pkg.sv
// AS2650 extended-I/O fabric: shared constants.
// State encodings, register offsets and reset defaults.
package as2650_io_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    localparam logic [1:0] REG_WAITCFG = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;

    localparam logic [7:0]  ERR_RDATA    = 8'hFF;
    localparam logic [7:0]  TIMEOUT_DEF  = 8'd16;
    localparam logic [31:0] REG_UNMAPPED = 32'hFFFF_FFFF;

endpackage

// File: rtl/as2650_io_wb_regs.sv
// AS2650 I/O fabric Wishbone register block.
// Holds wait-state, enable and timeout config plus sticky status.
module as2650_io_wb_regs #(
    parameter int NUM_DEV  = 4,
    parameter int WAIT_W   = 4,
    parameter int TO_RESET = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic                      wbs_we_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    output logic [31:0]               wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic [WAIT_W*NUM_DEV-1:0] waitcfg_o,
    output logic [NUM_DEV-1:0]        enable_o,
    output logic [7:0]                timeout_o,
    input  logic                      err_set_i,
    input  logic [7:0]                err_addr_i,
    input  logic                      done_pulse_i
);
    import as2650_io_pkg::*;

    localparam int CFG_W = WAIT_W * NUM_DEV;

    logic [CFG_W-1:0]   waitcfg_q, waitcfg_d;
    logic [NUM_DEV-1:0] enable_q, enable_d;
    logic [7:0]         timeout_q, timeout_d;
    logic               err_q, err_d;
    logic [7:0]         err_addr_q, err_addr_d;
    logic [7:0]         count_q, count_d;
    logic               ack_q;
    logic [31:0]        dat_q;
    logic [31:0]        rd_data;
    logic               acc;
    logic               unused_bits;

    assign acc         = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

    always_comb begin
        rd_data    = '0;
        waitcfg_d  = waitcfg_q;
        enable_d   = enable_q;
        timeout_d  = timeout_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        count_d    = count_q;
        unique case (wbs_adr_i[3:2])
            REG_WAITCFG: rd_data[CFG_W-1:0] = waitcfg_q;
            REG_CTRL: begin
                rd_data[NUM_DEV-1:0] = enable_q;
                rd_data[15:8]        = timeout_q;
            end
            REG_STATUS: begin
                rd_data[0]     = err_q;
                rd_data[15:8]  = err_addr_q;
                rd_data[23:16] = count_q;
            end
            default: rd_data = REG_UNMAPPED;
        endcase
        if (acc && wbs_we_i) begin
            unique case (wbs_adr_i[3:2])
                REG_WAITCFG: waitcfg_d = wbs_dat_i[CFG_W-1:0];
                REG_CTRL: begin
                    enable_d  = wbs_dat_i[NUM_DEV-1:0];
                    timeout_d = wbs_dat_i[15:8];
                end
                REG_STATUS: err_d = 1'b0;
                default: ;
            endcase
        end
        if (done_pulse_i) count_d = count_q + 8'd1;
        // a new error outranks a same-cycle clear
        if (err_set_i) begin
            err_d      = 1'b1;
            err_addr_d = err_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            waitcfg_q  <= '0;
            enable_q   <= '1;
            timeout_q  <= 8'(TO_RESET);
            err_q      <= 1'b0;
            err_addr_q <= '0;
            count_q    <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            waitcfg_q  <= waitcfg_d;
            enable_q   <= enable_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            count_q    <= count_d;
            ack_q      <= acc;
            if (acc) dat_q <= rd_data;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign waitcfg_o = waitcfg_q;
    assign enable_o  = enable_q;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/as2650_io_fabric.sv
// AS2650 extended-I/O fabric: decodes CPU I/O cycles onto
// NUM_DEV device channels with wait states and timeouts.
module as2650_io_fabric #(
    parameter int NUM_DEV   = 4,
    parameter int DEV_SEL_W = $clog2(NUM_DEV),
    parameter int WAIT_W    = 4,
    parameter int TO_RESET  = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   io_cyc,
    input  logic                   io_we,
    input  logic [7:0]             io_addr,
    input  logic [7:0]             io_wdata,
    output logic [7:0]             io_rdata,
    output logic                   io_ready,
    output logic                   io_err,
    output logic [7-DEV_SEL_W:0]   dev_addr,
    output logic [7:0]             dev_wdata,
    output logic [NUM_DEV-1:0]     dev_cyc,
    output logic [NUM_DEV-1:0]     dev_we,
    input  logic [8*NUM_DEV-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]     dev_ack,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic [31:0]            wbs_dat_o,
    input  logic                   wbs_we_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    output logic                   wbs_ack_o
);
    import as2650_io_pkg::*;

    localparam int LA_W = 8 - DEV_SEL_W;

    logic [2:0]                state_q, state_d;
    logic [7:0]                addr_q, addr_d;
    logic [7:0]                wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic [WAIT_W-1:0]         wcnt_q, wcnt_d;
    logic [7:0]                to_cnt_q, to_cnt_d;
    logic [7:0]                to_lim_q, to_lim_d;
    logic [7:0]                rdata_q, rdata_d;
    logic [WAIT_W*NUM_DEV-1:0] waitcfg;
    logic [NUM_DEV-1:0]        enable;
    logic [7:0]                timeout;
    logic [DEV_SEL_W-1:0]      idx_in, idx_q;
    logic [WAIT_W-1:0]         cfg_wait;
    logic [7:0]                rd_sel;

    assign idx_in = io_addr[7:LA_W];
    assign idx_q  = addr_q[7:LA_W];

    always_comb begin
        cfg_wait = '0;
        rd_sel   = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (idx_in == DEV_SEL_W'(i)) cfg_wait = waitcfg[WAIT_W*i +: WAIT_W];
            if (idx_q == DEV_SEL_W'(i))  rd_sel   = dev_rdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        wcnt_d   = wcnt_q;
        to_cnt_d = to_cnt_q;
        to_lim_d = to_lim_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (io_cyc) begin
                    addr_d   = io_addr;
                    wdata_d  = io_wdata;
                    we_d     = io_we;
                    wcnt_d   = cfg_wait;
                    to_cnt_d = '0;
                    to_lim_d = timeout;
                    if (!enable[idx_in])    state_d = ST_ERR;
                    else if (cfg_wait != '0) state_d = ST_WAIT;
                    else                     state_d = ST_ACCESS;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q == WAIT_W'(1)) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                to_cnt_d = to_cnt_q + 8'd1;
                if (dev_ack[idx_q]) begin
                    if (!we_q) rdata_d = rd_sel;
                    state_d = ST_DONE;
                end else if (to_lim_q != '0 && to_cnt_d == to_lim_q) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE:    state_d = ST_RELEASE;
            ST_ERR:     state_d = ST_RELEASE;
            ST_RELEASE: if (!io_cyc) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wcnt_q   <= '0;
            to_cnt_q <= '0;
            to_lim_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            wcnt_q   <= wcnt_d;
            to_cnt_q <= to_cnt_d;
            to_lim_q <= to_lim_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        dev_cyc = '0;
        dev_we  = '0;
        if (state_q == ST_ACCESS) begin
            dev_cyc[idx_q] = 1'b1;
            dev_we[idx_q]  = we_q;
        end
    end

    assign io_ready  = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign io_err    = (state_q == ST_ERR);
    assign io_rdata  = io_err ? ERR_RDATA : rdata_q;
    assign dev_addr  = addr_q[LA_W-1:0];
    assign dev_wdata = wdata_q;

    as2650_io_wb_regs #(
        .NUM_DEV  (NUM_DEV),
        .WAIT_W   (WAIT_W),
        .TO_RESET (TO_RESET)
    ) u_regs (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_ack_o    (wbs_ack_o),
        .waitcfg_o    (waitcfg),
        .enable_o     (enable),
        .timeout_o    (timeout),
        .err_set_i    (state_q == ST_ERR),
        .err_addr_i   (addr_q),
        .done_pulse_i (state_q == ST_DONE)
    );

endmodule

// File: tb/tb_as2650_io_fabric.sv
// Scoreboard bench for as2650_io_fabric (NUM_DEV=4).
// Directed I/O and Wishbone traffic; monitors pop expected responses.
module tb_as2650_io_fabric;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_cyc, io_we;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    logic        io_ready, io_err;
    logic [5:0]  dev_addr;
    logic [7:0]  dev_wdata;
    logic [3:0]  dev_cyc, dev_we, dev_ack, ack_mask;
    logic [31:0] dev_rdata;
    logic [31:0] wbs_adr, wbs_dat_i, wbs_dat_o;
    logic        wbs_we, wbs_cyc, wbs_stb, wbs_ack;

    always #5 clk = ~clk;

    assign dev_ack = dev_cyc & ack_mask;

    as2650_io_fabric dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .io_cyc    (io_cyc),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ready  (io_ready),
        .io_err    (io_err),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_cyc   (dev_cyc),
        .dev_we    (dev_we),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack),
        .wbs_adr_i (wbs_adr),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_we_i  (wbs_we),
        .wbs_cyc_i (wbs_cyc),
        .wbs_stb_i (wbs_stb),
        .wbs_ack_o (wbs_ack)
    );

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } io_exp_t;

    typedef struct packed {
        logic        rd;
        logic [31:0] dat;
    } wb_exp_t;

    io_exp_t io_q[$];
    wb_exp_t wb_q[$];
    int n_chk   = 0;
    int n_fail  = 0;
    int n_ready = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (io_ready) begin
            n_ready++;
            if (io_q.size() == 0) begin
                chk("io_unexpected_ready", {31'b0, io_ready}, 32'd0);
            end else begin
                io_exp_t e;
                e = io_q.pop_front();
                chk("io_rdata", {24'b0, io_rdata}, {24'b0, e.rdata});
                chk("io_err", {31'b0, io_err}, {31'b0, e.err});
            end
        end
        if (wbs_ack) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected_ack", {31'b0, wbs_ack}, 32'd0);
            end else begin
                wb_exp_t w;
                w = wb_q.pop_front();
                if (w.rd) chk("wb_rdata", wbs_dat_o, w.dat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
        wb_q.push_back('{rd: 1'b0, dat: 32'd0});
        wbs_adr   = {28'd0, r, 2'b00};
        wbs_dat_i = d;
        wbs_we    = 1'b1;
        wbs_cyc   = 1'b1;
        wbs_stb   = 1'b1;
        tick();
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
        tick();
    endtask

    task automatic wb_read(input logic [1:0] r, input logic [31:0] exp);
        wb_q.push_back('{rd: 1'b1, dat: exp});
        wbs_adr = {28'd0, r, 2'b00};
        wbs_we  = 1'b0;
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        tick();
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        tick();
    endtask

    task automatic wait_ready(input int maxc);
        int k;
        k = 0;
        while (!io_ready && k < maxc) begin
            tick();
            k++;
        end
        chk("ready_seen", {31'b0, io_ready}, 32'd1);
    endtask

    task automatic release_io();
        io_cyc = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_io_ready"}, {31'b0, io_ready}, 32'd0);
        chk({tag, "_io_err"}, {31'b0, io_err}, 32'd0);
        chk({tag, "_io_rdata"}, {24'b0, io_rdata}, 32'd0);
        chk({tag, "_dev_cyc"}, {28'b0, dev_cyc}, 32'd0);
        chk({tag, "_dev_addr"}, {26'b0, dev_addr}, 32'd0);
        chk({tag, "_dev_wdata"}, {24'b0, dev_wdata}, 32'd0);
        chk({tag, "_wbs_ack"}, {31'b0, wbs_ack}, 32'd0);
        chk({tag, "_wbs_dat"}, wbs_dat_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc;
        int r0;
        rst       = 1'b1;
        io_cyc    = 1'b0;
        io_we     = 1'b0;
        io_addr   = 8'h00;
        io_wdata  = 8'h00;
        wbs_adr   = '0;
        wbs_dat_i = '0;
        wbs_we    = 1'b0;
        wbs_cyc   = 1'b0;
        wbs_stb   = 1'b0;
        ack_mask  = 4'hF;
        dev_rdata = {8'h44, 8'h3C, 8'h22, 8'h11};
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state and defaults
        chk_outputs_zero("reset");
        wb_read(2'd0, 32'h0000_0000);
        wb_read(2'd1, 32'h0000_100F);
        wb_read(2'd2, 32'h0000_0000);
        wb_read(2'd3, 32'hFFFF_FFFF);

        // zero-wait read of device 2
        io_q.push_back('{rdata: 8'h3C, err: 1'b0});
        io_addr = 8'h85;
        io_we   = 1'b0;
        io_cyc  = 1'b1;
        tick();
        chk("rd_dev_cyc", {28'b0, dev_cyc}, 32'h4);
        chk("rd_dev_we", {28'b0, dev_we}, 32'h0);
        chk("rd_dev_addr", {26'b0, dev_addr}, 32'h05);
        chk("rd_not_ready_c1", {31'b0, io_ready}, 32'd0);
        tick();
        chk("rd_ready_c2", {31'b0, io_ready}, 32'd1);
        release_io();

        // three wait states on device 1, write
        wb_write(2'd0, 32'h0000_0030);
        io_q.push_back('{rdata: 8'h3C, err: 1'b0});
        io_addr  = 8'h40;
        io_wdata = 8'hA5;
        io_we    = 1'b1;
        io_cyc   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wr_wait_no_cyc", {28'b0, dev_cyc}, 32'h0);
        end
        tick();
        chk("wr_dev_cyc", {28'b0, dev_cyc}, 32'h2);
        chk("wr_dev_we", {28'b0, dev_we}, 32'h2);
        chk("wr_dev_wdata", {24'b0, dev_wdata}, 32'hA5);
        chk("wr_dev_addr", {26'b0, dev_addr}, 32'h00);
        tick();
        chk("wr_ready", {31'b0, io_ready}, 32'd1);
        release_io();
        io_we = 1'b0;
        wb_read(2'd2, 32'h0002_0000);

        // disabled device 0
        wb_write(2'd1, 32'h0000_100E);
        io_q.push_back('{rdata: 8'hFF, err: 1'b1});
        io_addr = 8'h10;
        io_cyc  = 1'b1;
        tick();
        chk("dis_err", {31'b0, io_err}, 32'd1);
        chk("dis_rdata", {24'b0, io_rdata}, 32'hFF);
        chk("dis_no_cyc", {28'b0, dev_cyc}, 32'h0);
        release_io();
        wb_read(2'd2, 32'h0002_1001);

        // timeout of 5 on silent device 3
        wb_write(2'd1, 32'h0000_050F);
        ack_mask = 4'h0;
        io_q.push_back('{rdata: 8'hFF, err: 1'b1});
        io_addr = 8'hC7;
        io_cyc  = 1'b1;
        nc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dev_cyc == 4'h8) nc++;
        end
        chk("to_cyc_cycles", nc, 32'd5);
        tick();
        chk("to_err", {31'b0, io_err}, 32'd1);
        chk("to_cyc_dropped", {28'b0, dev_cyc}, 32'h0);
        release_io();
        ack_mask = 4'hF;
        wb_read(2'd2, 32'h0002_C701);
        wb_write(2'd2, 32'h0000_0000);
        wb_read(2'd2, 32'h0002_C700);

        // io_cyc held across completion
        io_q.push_back('{rdata: 8'h11, err: 1'b0});
        io_addr = 8'h03;
        io_cyc  = 1'b1;
        nc = 0;
        r0 = n_ready;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dev_cyc != 4'h0) nc++;
        end
        chk("held_cyc_bursts", nc, 32'd1);
        chk("held_ready_count", n_ready - r0, 32'd1);
        release_io();
        io_q.push_back('{rdata: 8'h3C, err: 1'b0});
        io_addr = 8'h86;
        io_cyc  = 1'b1;
        wait_ready(10);
        release_io();

        // reset while in WAIT
        io_addr = 8'h40;
        io_cyc  = 1'b1;
        tick();
        tick();
        rst    = 1'b1;
        io_cyc = 1'b0;
        tick();
        rst = 1'b0;
        chk_outputs_zero("rst_wait");
        r0 = n_ready;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_wait_no_ready", n_ready - r0, 32'd0);
        wb_read(2'd0, 32'h0000_0000);
        wb_read(2'd1, 32'h0000_100F);
        wb_read(2'd2, 32'h0000_0000);

        // STATUS clear coincident with an error
        wb_write(2'd1, 32'h0000_100E);
        io_q.push_back('{rdata: 8'hFF, err: 1'b1});
        io_addr = 8'h10;
        io_cyc  = 1'b1;
        tick();
        chk("sim_err", {31'b0, io_err}, 32'd1);
        wb_q.push_back('{rd: 1'b0, dat: 32'd0});
        wbs_adr   = 32'h8;
        wbs_dat_i = 32'h0;
        wbs_we    = 1'b1;
        wbs_cyc   = 1'b1;
        wbs_stb   = 1'b1;
        io_cyc    = 1'b0;
        tick();
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
        tick();
        wb_read(2'd2, 32'h0000_1001);

        // reset coincident with clear and error
        io_q.push_back('{rdata: 8'hFF, err: 1'b1});
        io_addr = 8'h10;
        io_cyc  = 1'b1;
        tick();
        rst       = 1'b1;
        wbs_adr   = 32'h8;
        wbs_we    = 1'b1;
        wbs_cyc   = 1'b1;
        wbs_stb   = 1'b1;
        io_cyc    = 1'b0;
        tick();
        rst     = 1'b0;
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
        chk_outputs_zero("rst_sim");
        tick();
        wb_read(2'd2, 32'h0000_0000);
        wb_read(2'd1, 32'h0000_100F);
        wb_read(2'd0, 32'h0000_0000);

        tick();
        chk("io_queue_empty", io_q.size(), 32'd0);
        chk("wb_queue_empty", wb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/as2650_io_fabric.md
Name: as2650_io_fabric

Overview:
- Parametrised successor to the fixed 4-device internal I/O multiplexer in the AS2650 wrapper.
- Decodes CPU extended-I/O accesses to NUM_DEV peripheral channels.
- Inserts per-device programmable wait states and waits for a per-device acknowledge.
- Times out unresponsive devices and reports errors through a Wishbone-visible config/status register block.

Parameters:
- NUM_DEV, 4, number of device channels; power of two, 2..8.
- DEV_SEL_W, $clog2(NUM_DEV), number of upper io_addr bits that select the device (derived).
- WAIT_W, 4, width of each per-device wait-state field.
- TO_RESET, 16, reset value of the timeout limit.

Ports:
- wb_clk_i  in  1  single system clock
- wb_rst_i  in  1  synchronous, active-high reset
- io_cyc  in  1  CPU I/O cycle request; level, held until io_ready
- io_we  in  1  CPU write strobe; sampled with io_cyc
- io_addr  in  8  CPU I/O address
- io_wdata  in  8  CPU write data
- io_rdata  out  8  read data; valid while io_ready=1
- io_ready  out  1  one-cycle transfer-complete pulse
- io_err  out  1  one-cycle error flag, coincident with io_ready
- dev_addr  out  8-DEV_SEL_W  latched local address
- dev_wdata  out  8  latched write data
- dev_cyc  out  NUM_DEV  one-hot device cycle strobe
- dev_we  out  NUM_DEV  one-hot device write strobe
- dev_rdata  in  8*NUM_DEV  packed read data; device i occupies [8i+7:8i]
- dev_ack  in  NUM_DEV  device acknowledge
- wbs_adr_i  in  32  Wishbone address; bits [3:2] select the register
- wbs_dat_i  in  32  Wishbone write data
- wbs_dat_o  out  32  Wishbone read data
- wbs_we_i  in  1  Wishbone write enable
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_ack_o  out  1  Wishbone acknowledge

Behaviour:
- Reset (wb_rst_i synchronous, active-high):
  - FSM goes to IDLE and all outputs are 0.
  - WAITCFG=0, ENABLE mask all-ones, TIMEOUT=TO_RESET.
  - STATUS cleared. In-flight transfers are dropped; no io_ready is produced.
- Device index: idx = io_addr[7:8-DEV_SEL_W]. dev_addr = the remaining low bits.
- FSM states: IDLE, WAIT, ACCESS, DONE, ERR, RELEASE.
- IDLE:
  - When io_cyc=1, latch addr, wdata, we and idx.
  - If ENABLE[idx]=0, go to ERR.
  - Otherwise load the wait counter with WAITCFG[idx]. Go to WAIT if it is nonzero, else ACCESS.
- WAIT: decrement each cycle; at 1, go to ACCESS. N wait states add exactly N cycles.
- ACCESS:
  - dev_cyc[idx]=1, and dev_we[idx]=latched we. The timeout counter increments each cycle.
  - If dev_ack[idx]=1, capture dev_rdata[idx] into io_rdata and go to DONE.
  - Else, if TIMEOUT≠0 and the counter equals TIMEOUT, go to ERR.
  - Acks from other devices are ignored.
- DONE: io_ready=1 for one cycle, then RELEASE.
- ERR:
  - io_ready=1, io_err=1, io_rdata=8'hFF for one cycle.
  - Set the sticky err bit and record the address in STATUS. Then go to RELEASE.
- RELEASE: wait for io_cyc=0, then IDLE. This prevents a held request from repeating.
- Minimum latency: io_cyc sampled at cycle 0, dev_cyc at cycle 1 with same-cycle ack, io_ready at cycle 2.
- Write transfers:
  - io_rdata holds its last read value.
  - The transaction counter (8-bit, wraps 255→0) increments on every DONE.
- Wishbone handshake:
  - When cyc&stb is high and ack is 0, the access is performed and wbs_ack_o is asserted the next cycle for one cycle.
  - wbs_dat_o is registered.
- Register map (wbs_adr_i[3:2]):
  - 0 WAITCFG: RW. Field i = bits [WAIT_W*i+WAIT_W-1 : WAIT_W*i].
  - 1 CTRL: RW. [NUM_DEV-1:0] ENABLE, [15:8] TIMEOUT.
  - 2 STATUS: [0] err sticky, [15:8] last error address, [23:16] transaction count. Any write clears err only.
  - 3 reads 32'hFFFFFFFF; writes are ignored.
  - Unimplemented bits read 0.
- Simultaneous events:
  - A config write during a transfer does not affect the latched wait count or an in-flight ACCESS.
  - A STATUS clear in the same cycle as an error set leaves err=1.
  - io_cyc dropping mid-transfer is ignored; the transfer completes normally.

Decomposition:
- Package as2650_io_pkg holds:
  - FSM state enumeration;
  - register offsets REG_WAITCFG, REG_CTRL, REG_STATUS;
  - ERR_RDATA=8'hFF;
  - reset defaults.
- Sub-module as2650_io_wb_regs contains the Wishbone slave and register file. It exports WAITCFG, ENABLE and TIMEOUT, and takes err_set, err_addr and done_pulse.
- The FSM and datapath live in the top module.

Test Plan:
- Read with WAITCFG=0, device 2 (NUM_DEV=4, io_addr=8'h85), dev_ack[2] in the same cycle, dev_rdata[2]=8'h3C -> dev_cyc=4'b0100 with dev_addr=6'h05 on cycle 1; io_ready on cycle 2 with io_rdata=8'h3C, io_err=0.
- WAITCFG field1=3, write io_addr=8'h40, io_wdata=8'hA5 -> dev_cyc[1] asserts 3 cycles later than the zero-wait case, with dev_we[1]=1 and dev_wdata=8'hA5; transaction count becomes 1.
- ENABLE=4'b1110, access io_addr=8'h10 -> io_ready=io_err=1 on cycle 1, io_rdata=8'hFF; STATUS reads 32'h00001001; no dev_cyc asserted.
- TIMEOUT=5, dev_ack tied low -> dev_cyc high for 5 cycles, then io_err pulse; a STATUS write clears err while the address is retained.
- io_cyc held high across completion -> exactly one dev_cyc burst and one io_ready; a new transfer starts only after io_cyc drops.
- Assert wb_rst_i during WAIT, and separately in the same cycle as a STATUS clear/error -> after reset, all outputs are 0, no io_ready, and registers hold their defaults; without reset, the simultaneous clear and error leave err=1.
